// File: rtl/hazard_stall_controller.sv
// Load-use stall, taken-branch flush and multi-cycle mul/div freeze control for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds Stall_Count / Flush_Count performance counters.
module hazard_stall_controller #(
   parameter int MD_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] IF_ID_Rs1,
   input  logic [4:0] IF_ID_Rs2,
   input  logic       IF_ID_UsesRs2,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] ID_EX_RegisterRd,
   input  logic       ID_EX_MulDiv,
   input  logic       EX_Branch_Taken,
   output logic       PC_Write,
   output logic       IF_ID_Write,
   output logic       ID_EX_Write,
   output logic       ID_EX_Bubble,
   output logic       EX_MEM_Bubble,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Flush,
   output logic       MD_Done
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] Stall_Count,
   output logic [31:0] Flush_Count
`endif
);

   localparam int CNT_W = $clog2(MD_LATENCY) + 1;

   typedef enum logic {RUN = 1'b0, BUSY = 1'b1} stateType;

   stateType         stateReg, stateNext;
   logic [CNT_W-1:0] cntReg, cntNext;
   logic             loadUse;

   assign loadUse = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                    ((ID_EX_RegisterRd == IF_ID_Rs1) ||
                     (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_Rs2)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= RUN;
         cntReg   <= '0;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
      end
   end

   // cnt holds the remaining BUSY cycles; the start cycle in RUN is already the first freeze
   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      case (stateReg)
         RUN: begin
            if (ID_EX_MulDiv && (MD_LATENCY > 1)) begin
               stateNext = BUSY;
               cntNext   = CNT_W'(MD_LATENCY - 1);
            end
         end
         BUSY: begin
            if (cntReg == CNT_W'(1)) begin
               stateNext = RUN;
               cntNext   = '0;
            end else begin
               cntNext = cntReg - CNT_W'(1);
            end
         end
         default: begin
            stateNext = RUN;
            cntNext   = '0;
         end
      endcase
   end

   always_comb begin
      PC_Write      = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      MD_Done       = 1'b0;
      case (stateReg)
         RUN: begin
            // Priority: mul/div freeze, then branch flush, then load-use stall
            if (ID_EX_MulDiv && (MD_LATENCY > 1)) begin
               PC_Write      = 1'b0;
               IF_ID_Write   = 1'b0;
               ID_EX_Write   = 1'b0;
               EX_MEM_Bubble = 1'b1;
            end else begin
               if (EX_Branch_Taken) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
               end else if (loadUse) begin
                  PC_Write     = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end
               if (ID_EX_MulDiv) begin
                  MD_Done = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cntReg > CNT_W'(1)) begin
               PC_Write      = 1'b0;
               IF_ID_Write   = 1'b0;
               ID_EX_Write   = 1'b0;
               EX_MEM_Bubble = 1'b1;
            end else begin
               MD_Done = 1'b1;
            end
         end
         default: begin
            PC_Write = 1'b1;
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stallCountReg, flushCountReg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCountReg <= '0;
         flushCountReg <= '0;
      end else begin
         stallCountReg <= stallCountReg + {31'd0, ~PC_Write};
         flushCountReg <= flushCountReg + {31'd0, IF_ID_Flush};
      end
   end

   assign Stall_Count = stallCountReg;
   assign Flush_Count = flushCountReg;
`endif

endmodule
